// File: rtl/mul_reservation_station.sv
// mul_reservation_station
//   Reservation station in front of a multiply/divide unit. Holds up to
//   NUM_ENTRIES waiting operations, snoops the common data bus for missing
//   operands and hands the lowest-index ready entry to the functional unit.
//
// Ports
//   Clock, Reset                 clock, asynchronous active-high reset
//   issue_valid/op/vj/vk/qj/qk   issue request (op 1=mul, 2=div; q=0 means value valid)
//   issue_ready, issue_tag       a free entry exists / tag it will receive
//   cdb_valid, cdb_tag, CDB      result broadcast bus
//   fu_ready                     functional unit can take an operation
//   disp_valid, OP, disp_tag,
//   resv_out1, resv_out2         registered dispatch to the functional unit
//   busy_count                   number of occupied entries
module mul_reservation_station #(
  parameter int NUM_ENTRIES = 3,
  parameter int DATA_W      = 16,
  parameter int TAG_W       = 3,
  parameter int BASE_TAG    = 4
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic                               issue_valid,
  input  logic [1:0]                         issue_op,
  input  logic [DATA_W-1:0]                  issue_vj,
  input  logic [DATA_W-1:0]                  issue_vk,
  input  logic [TAG_W-1:0]                   issue_qj,
  input  logic [TAG_W-1:0]                   issue_qk,
  output logic                               issue_ready,
  output logic [TAG_W-1:0]                   issue_tag,
  input  logic                               cdb_valid,
  input  logic [TAG_W-1:0]                   cdb_tag,
  input  logic [DATA_W-1:0]                  CDB,
  input  logic                               fu_ready,
  output logic                               disp_valid,
  output logic [1:0]                         OP,
  output logic [TAG_W-1:0]                   disp_tag,
  output logic [DATA_W-1:0]                  resv_out1,
  output logic [DATA_W-1:0]                  resv_out2,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   busy_count
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

  // Entry storage
  logic [NUM_ENTRIES-1:0] busy_q, busy_d;
  logic [1:0]             op_q [NUM_ENTRIES];
  logic [1:0]             op_d [NUM_ENTRIES];
  logic [DATA_W-1:0]      vj_q [NUM_ENTRIES];
  logic [DATA_W-1:0]      vj_d [NUM_ENTRIES];
  logic [DATA_W-1:0]      vk_q [NUM_ENTRIES];
  logic [DATA_W-1:0]      vk_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       qj_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       qj_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       qk_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       qk_d [NUM_ENTRIES];
  logic [CNT_W-1:0]       count_q, count_d;

  // Dispatch output registers
  logic                   dispValid_q;
  logic [1:0]             dispOp_q;
  logic [TAG_W-1:0]       dispTag_q;
  logic [DATA_W-1:0]      dispVj_q, dispVk_q;

  // Selection signals
  logic [NUM_ENTRIES-1:0] entryReady;
  logic                   freeFound, readyFound;
  logic [IDX_W-1:0]       freeIdx, readyIdx;
  logic                   issueAccept, dispFire, cdbHit;
  logic [1:0]             selOp;
  logic [DATA_W-1:0]      selVj, selVk;

  // Priority pick of the lowest free and lowest ready entry. The loops run
  // downward so the last (lowest) match wins. Both use registered state only.
  always_comb begin
    freeFound  = 1'b0;
    freeIdx    = '0;
    readyFound = 1'b0;
    readyIdx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      entryReady[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    end
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        freeFound = 1'b1;
        freeIdx   = IDX_W'(i);
      end
      if (entryReady[i]) begin
        readyFound = 1'b1;
        readyIdx   = IDX_W'(i);
      end
    end
  end

  assign issue_ready = freeFound;
  assign issue_tag   = TAG_W'(BASE_TAG) + TAG_W'(freeIdx);
  assign issueAccept = issue_valid && freeFound && ((issue_op == 2'd1) || (issue_op == 2'd2));
  assign dispFire    = fu_ready && readyFound;
  // Tag 0 denotes "value present", so a broadcast with tag 0 never matches.
  assign cdbHit      = cdb_valid && (cdb_tag != '0);

  // Operand mux for the entry being dispatched
  always_comb begin
    selOp = '0;
    selVj = '0;
    selVk = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (IDX_W'(i) == readyIdx) begin
        selOp = op_q[i];
        selVj = vj_q[i];
        selVk = vk_q[i];
      end
    end
  end

  // Next-state for every entry: CDB snooping on waiting entries, busy clear
  // on dispatch, and a write of the issued operation into the free slot.
  // The issued slot is free and the dispatched slot is busy, so they never
  // collide. An issue that names the tag currently on the CDB grabs the value.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      op_d[i] = op_q[i];
      vj_d[i] = vj_q[i];
      vk_d[i] = vk_q[i];
      qj_d[i] = qj_q[i];
      qk_d[i] = qk_q[i];

      if (busy_q[i] && cdbHit) begin
        if (qj_q[i] == cdb_tag) begin
          vj_d[i] = CDB;
          qj_d[i] = '0;
        end
        if (qk_q[i] == cdb_tag) begin
          vk_d[i] = CDB;
          qk_d[i] = '0;
        end
      end

      if (dispFire && (IDX_W'(i) == readyIdx)) begin
        busy_d[i] = 1'b0;
      end

      if (issueAccept && (IDX_W'(i) == freeIdx)) begin
        busy_d[i] = 1'b1;
        op_d[i]   = issue_op;
        if (cdbHit && (issue_qj == cdb_tag)) begin
          vj_d[i] = CDB;
          qj_d[i] = '0;
        end else begin
          vj_d[i] = issue_vj;
          qj_d[i] = issue_qj;
        end
        if (cdbHit && (issue_qk == cdb_tag)) begin
          vk_d[i] = CDB;
          qk_d[i] = '0;
        end else begin
          vk_d[i] = issue_vk;
          qk_d[i] = issue_qk;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (issueAccept && !dispFire) begin
      count_d = count_q + CNT_W'(1);
    end else if (!issueAccept && dispFire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      busy_q      <= '0;
      count_q     <= '0;
      dispValid_q <= 1'b0;
      dispOp_q    <= '0;
      dispTag_q   <= '0;
      dispVj_q    <= '0;
      dispVk_q    <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        op_q[i] <= '0;
        vj_q[i] <= '0;
        vk_q[i] <= '0;
        qj_q[i] <= '0;
        qk_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        op_q[i] <= op_d[i];
        vj_q[i] <= vj_d[i];
        vk_q[i] <= vk_d[i];
        qj_q[i] <= qj_d[i];
        qk_q[i] <= qk_d[i];
      end
      // Payload fields hold their last value when nothing is dispatched.
      if (dispFire) begin
        dispValid_q <= 1'b1;
        dispOp_q    <= selOp;
        dispTag_q   <= TAG_W'(BASE_TAG) + TAG_W'(readyIdx);
        dispVj_q    <= selVj;
        dispVk_q    <= selVk;
      end else begin
        dispValid_q <= 1'b0;
      end
    end
  end

  assign disp_valid = dispValid_q;
  assign OP         = dispOp_q;
  assign disp_tag   = dispTag_q;
  assign resv_out1  = dispVj_q;
  assign resv_out2  = dispVk_q;
  assign busy_count = count_q;

endmodule

// File: tb/tb_mul_reservation_station.sv
// tb_mul_reservation_station
//   Table-driven directed test of mul_reservation_station with default
//   parameters (3 entries, tags 4..6), followed by hand-written reset
//   sequences.
module tb_mul_reservation_station;

  logic        Clock;
  logic        Reset;
  logic        issue_valid;
  logic [1:0]  issue_op;
  logic [15:0] issue_vj, issue_vk;
  logic [2:0]  issue_qj, issue_qk;
  logic        issue_ready;
  logic [2:0]  issue_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] CDB;
  logic        fu_ready;
  logic        disp_valid;
  logic [1:0]  OP;
  logic [2:0]  disp_tag;
  logic [15:0] resv_out1, resv_out2;
  logic [1:0]  busy_count;

  int vecCount  = 0;
  int missCount = 0;

  mul_reservation_station #(
    .NUM_ENTRIES(3), .DATA_W(16), .TAG_W(3), .BASE_TAG(4)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_ready(issue_ready), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .CDB(CDB),
    .fu_ready(fu_ready),
    .disp_valid(disp_valid), .OP(OP), .disp_tag(disp_tag),
    .resv_out1(resv_out1), .resv_out2(resv_out2),
    .busy_count(busy_count)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    logic        iv;
    logic [1:0]  op;
    logic [15:0] vj, vk;
    logic [2:0]  qj, qk;
    logic        cv;
    logic [2:0]  ct;
    logic [15:0] cdb;
    logic        fu;
    logic        eReady;
    logic [2:0]  eTag;
    logic        chkTag;
    logic        eDv;
    logic [1:0]  eOp;
    logic [2:0]  eDt;
    logic [15:0] eO1, eO2;
    logic [1:0]  eCnt;
  } vec_t;

  localparam int NUM_VECS = 28;
  vec_t vecs [NUM_VECS];

  function automatic vec_t mkVec(
    input int iv, input int op, input int vj, input int vk, input int qj, input int qk,
    input int cv, input int ct, input int cdb, input int fu,
    input int eReady, input int eTag, input int chkTag,
    input int eDv, input int eOp, input int eDt, input int eO1, input int eO2, input int eCnt);
    vec_t v;
    v.iv = 1'(iv);  v.op = 2'(op);  v.vj = 16'(vj);  v.vk = 16'(vk);
    v.qj = 3'(qj);  v.qk = 3'(qk);  v.cv = 1'(cv);   v.ct = 3'(ct);
    v.cdb = 16'(cdb); v.fu = 1'(fu);
    v.eReady = 1'(eReady); v.eTag = 3'(eTag); v.chkTag = 1'(chkTag);
    v.eDv = 1'(eDv); v.eOp = 2'(eOp); v.eDt = 3'(eDt);
    v.eO1 = 16'(eO1); v.eO2 = 16'(eO2); v.eCnt = 2'(eCnt);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    issue_valid = v.iv;
    issue_op    = v.op;
    issue_vj    = v.vj;
    issue_vk    = v.vk;
    issue_qj    = v.qj;
    issue_qk    = v.qk;
    cdb_valid   = v.cv;
    cdb_tag     = v.ct;
    CDB         = v.cdb;
    fu_ready    = v.fu;
  endtask

  task automatic idleInputs(input logic fu);
    applyStimulus(mkVec(0,0,0,0,0,0, 0,0,0,int'(fu), 0,0,0, 0,0,0,0,0,0));
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkOutput($sformatf("v%0d issue_ready", idx), 32'(issue_ready), 32'(v.eReady));
    if (v.chkTag)
      checkOutput($sformatf("v%0d issue_tag", idx), 32'(issue_tag), 32'(v.eTag));
    checkOutput($sformatf("v%0d disp_valid", idx), 32'(disp_valid), 32'(v.eDv));
    checkOutput($sformatf("v%0d OP", idx), 32'(OP), 32'(v.eOp));
    checkOutput($sformatf("v%0d disp_tag", idx), 32'(disp_tag), 32'(v.eDt));
    checkOutput($sformatf("v%0d resv_out1", idx), 32'(resv_out1), 32'(v.eO1));
    checkOutput($sformatf("v%0d resv_out2", idx), 32'(resv_out2), 32'(v.eO2));
    checkOutput($sformatf("v%0d busy_count", idx), 32'(busy_count), 32'(v.eCnt));
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, " disp_valid"}, 32'(disp_valid), 32'd0);
    checkOutput({tag, " OP"}, 32'(OP), 32'd0);
    checkOutput({tag, " disp_tag"}, 32'(disp_tag), 32'd0);
    checkOutput({tag, " resv_out1"}, 32'(resv_out1), 32'd0);
    checkOutput({tag, " resv_out2"}, 32'(resv_out2), 32'd0);
    checkOutput({tag, " busy_count"}, 32'(busy_count), 32'd0);
    checkOutput({tag, " issue_ready"}, 32'(issue_ready), 32'd1);
    checkOutput({tag, " issue_tag"}, 32'(issue_tag), 32'd4);
  endtask

  initial begin
    // Fields: iv,op,vj,vk,qj,qk, cv,ct,cdb,fu, eReady,eTag,chkTag, eDv,eOp,eDt,eO1,eO2, eCnt
    // Basic multiply, minimum latency
    vecs[0]  = mkVec(1,1,3,5,0,0,     0,0,0,1,   1,5,1, 0,0,0,0,0,     1);
    vecs[1]  = mkVec(0,0,0,0,0,0,     0,0,0,1,   1,4,1, 1,1,4,3,5,     0);
    vecs[2]  = mkVec(0,0,0,0,0,0,     0,0,0,1,   1,4,1, 0,1,4,3,5,     0);
    // Divide waiting on tag 6, later captured from the CDB
    vecs[3]  = mkVec(1,2,99,8,6,0,    0,0,0,1,   1,5,1, 0,1,4,3,5,     1);
    vecs[4]  = mkVec(0,0,0,0,0,0,     0,0,0,1,   1,5,1, 0,1,4,3,5,     1);
    vecs[5]  = mkVec(0,0,0,0,0,0,     1,6,40,1,  1,5,1, 0,1,4,3,5,     1);
    vecs[6]  = mkVec(0,0,0,0,0,0,     0,0,0,1,   1,4,1, 1,2,4,40,8,    0);
    vecs[7]  = mkVec(0,0,0,0,0,0,     0,0,0,1,   1,4,1, 0,2,4,40,8,    0);
    // Fill the station with the unit stalled, fourth issue is dropped
    vecs[8]  = mkVec(1,1,1,2,0,0,     0,0,0,0,   1,5,1, 0,2,4,40,8,    1);
    vecs[9]  = mkVec(1,2,3,4,0,0,     0,0,0,0,   1,6,1, 0,2,4,40,8,    2);
    vecs[10] = mkVec(1,1,5,6,0,0,     0,0,0,0,   0,0,0, 0,2,4,40,8,    3);
    vecs[11] = mkVec(1,1,7,7,0,0,     0,0,0,0,   0,0,0, 0,2,4,40,8,    3);
    vecs[12] = mkVec(0,0,0,0,0,0,     0,0,0,1,   1,4,1, 1,1,4,1,2,     2);
    vecs[13] = mkVec(0,0,0,0,0,0,     0,0,0,1,   1,4,1, 1,2,5,3,4,     1);
    vecs[14] = mkVec(0,0,0,0,0,0,     0,0,0,1,   1,4,1, 1,1,6,5,6,     0);
    vecs[15] = mkVec(0,0,0,0,0,0,     0,0,0,1,   1,4,1, 0,1,6,5,6,     0);
    // Issue coincident with matching broadcast on qk
    vecs[16] = mkVec(1,1,9,0,0,5,     1,5,7,0,   1,5,1, 0,1,6,5,6,     1);
    vecs[17] = mkVec(0,0,0,0,0,0,     0,0,0,1,   1,4,1, 1,1,4,9,7,     0);
    // Issue, CDB capture and dispatch in one cycle on different entries
    vecs[18] = mkVec(1,2,10,0,0,6,    0,0,0,0,   1,5,1, 0,1,4,9,7,     1);
    vecs[19] = mkVec(1,1,11,12,0,0,   0,0,0,0,   1,6,1, 0,1,4,9,7,     2);
    vecs[20] = mkVec(1,2,13,14,0,0,   1,6,20,1,  1,5,1, 1,1,5,11,12,   2);
    vecs[21] = mkVec(0,0,0,0,0,0,     0,0,0,1,   1,4,1, 1,2,4,10,20,   1);
    vecs[22] = mkVec(0,0,0,0,0,0,     0,0,0,1,   1,4,1, 1,2,6,13,14,   0);
    // Broadcast with tag 0 must not overwrite anything
    vecs[23] = mkVec(1,1,21,22,0,0,   1,0,99,0,  1,5,1, 0,2,6,13,14,   1);
    vecs[24] = mkVec(0,0,0,0,0,0,     1,0,99,0,  1,5,1, 0,2,6,13,14,   1);
    vecs[25] = mkVec(0,0,0,0,0,0,     0,0,0,1,   1,4,1, 1,1,4,21,22,   0);
    // Illegal opcodes 0 and 3 are ignored
    vecs[26] = mkVec(1,0,50,51,0,0,   0,0,0,1,   1,4,1, 0,1,4,21,22,   0);
    vecs[27] = mkVec(1,3,50,51,0,0,   0,0,0,1,   1,4,1, 0,1,4,21,22,   0);

    // Power-on reset, checked while still asserted
    Reset = 1'b1;
    idleInputs(1'b0);
    #3;
    checkCleared("por");
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock);
    #1;

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i]);
      @(posedge Clock);
      #1;
      checkVector(i, vecs[i]);
    end

    // Asynchronous reset with two occupied entries
    applyStimulus(mkVec(1,1,4,5,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0));
    @(posedge Clock);
    #1;
    applyStimulus(mkVec(1,2,6,7,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0));
    @(posedge Clock);
    #1;
    idleInputs(1'b0);
    checkOutput("pre-reset busy_count", 32'(busy_count), 32'd2);
    #2;
    Reset = 1'b1;
    #1;
    checkCleared("async");
    @(negedge Clock);
    Reset = 1'b0;
    idleInputs(1'b1);
    for (int c = 0; c < 3; c++) begin
      @(posedge Clock);
      #1;
      checkOutput($sformatf("post-reset c%0d disp_valid", c), 32'(disp_valid), 32'd0);
      checkOutput($sformatf("post-reset c%0d busy_count", c), 32'(busy_count), 32'd0);
    end

    // First issue after reset receives tag 4 and dispatches normally
    applyStimulus(mkVec(1,1,2,3,0,0, 0,0,0,1, 0,0,0, 0,0,0,0,0,0));
    #1;
    checkOutput("first issue_tag", 32'(issue_tag), 32'd4);
    @(posedge Clock);
    #1;
    idleInputs(1'b1);
    @(posedge Clock);
    #1;
    checkOutput("first disp_valid", 32'(disp_valid), 32'd1);
    checkOutput("first disp_tag", 32'(disp_tag), 32'd4);
    checkOutput("first resv_out1", 32'(resv_out1), 32'd2);
    checkOutput("first resv_out2", 32'(resv_out2), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/mul_reservation_station.md
MUL_RESERVATION_STATION -- requirements
Module: mul_reservation_station

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 3: number of station entries.
REQ-002 SHALL have parameter DATA_W, default 16: operand and CDB width.
REQ-003 SHALL have parameter TAG_W, default 3: tag width; tag 0 means "value present".
REQ-004 SHALL have parameter BASE_TAG, default 4: tag of entry 0; entry i owns tag BASE_TAG+i (nonzero, fits in TAG_W).
REQ-005 SHALL have port Clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port issue_valid  in  1  issue request.
REQ-008 SHALL have port issue_op  in  2  1=multiply, 2=divide.
REQ-009 SHALL have ports issue_vj, issue_vk  in  DATA_W  operand values.
REQ-010 SHALL have ports issue_qj, issue_qk  in  TAG_W  producer tags (0 = value valid).
REQ-011 SHALL have port issue_ready  out  1  high when at least one entry is free.
REQ-012 SHALL have port issue_tag  out  TAG_W  tag the next accepted issue receives.
REQ-013 SHALL have ports cdb_valid  in  1, cdb_tag  in  TAG_W, CDB  in  DATA_W  broadcast result bus.
REQ-014 SHALL have port fu_ready  in  1  multiplier unit can accept an operation.
REQ-015 SHALL have ports disp_valid  out  1, OP  out  2, disp_tag  out  TAG_W, resv_out1/resv_out2  out  DATA_W  dispatch to the multiplier unit.
REQ-016 SHALL have port busy_count  out  clog2(NUM_ENTRIES+1)  occupied entries.

Function
REQ-017 Each entry SHALL hold busy, op, Vj, Vk, Qj, Qk.
REQ-018 Issue SHALL be accepted at a rising edge when issue_valid && issue_ready && issue_op in {1,2}.
REQ-019 Accepted issue SHALL write the lowest-index free entry; issue_tag SHALL combinationally equal BASE_TAG + that index.
REQ-020 Issue with issue_op 0 or 3 SHALL be ignored with no state change.
REQ-021 issue_ready and the free-entry choice SHALL derive from registered busy bits only; an entry freed at edge N is reusable from edge N+1.
REQ-022 At each edge with cdb_valid, every busy entry with Qj==cdb_tag SHALL load Vj<=CDB and Qj<=0; likewise for Qk/Vk.
REQ-023 Issue coincident with a matching CDB broadcast (issue_qj or issue_qk == cdb_tag, cdb_valid=1) SHALL capture CDB directly and store Q=0.
REQ-024 cdb_tag 0 SHALL never match.
REQ-025 Entry SHALL be ready when busy && Qj==0 && Qk==0, evaluated on registered state; an operand captured at edge N is dispatchable from edge N+1.
REQ-026 At an edge with fu_ready=1 and at least one ready entry, the lowest-index ready entry SHALL be dispatched: disp_valid<=1, OP, disp_tag, resv_out1<=Vj, resv_out2<=Vk registered, and the entry's busy cleared.
REQ-027 Otherwise disp_valid SHALL be 0 at the next edge, with the other dispatch outputs holding their last values.
REQ-028 disp_valid SHALL be a one-cycle pulse per dispatched entry; at most one dispatch per cycle.
REQ-029 Minimum latency SHALL be: issue with both Q=0 at edge N -> disp_valid high after edge N+1, given fu_ready.
REQ-030 Issue, CDB capture and dispatch SHALL all be able to occur in the same cycle on different entries.
REQ-031 busy_count SHALL be +1 on issue, -1 on dispatch, unchanged on both or neither; range 0..NUM_ENTRIES.

Reset
REQ-032 Reset high SHALL immediately, without a clock edge, clear all busy bits and all Q fields and set disp_valid=0, OP=0, disp_tag=0, resv_out1=0, resv_out2=0, busy_count=0.
REQ-033 Reset mid-operation SHALL discard all pending entries; the first issue after reset deasserts gets tag BASE_TAG.

Verification
REQ-034 Issue op=1, Vj=3, Vk=5, Q=0/0, fu_ready=1 -> next cycle disp_valid=1, OP=1, resv_out1=3, resv_out2=5, disp_tag=4.
REQ-035 Issue op=2, Qj=6, Vk=8; later cdb_valid, cdb_tag=6, CDB=40 -> one cycle after capture: dispatch resv_out1=40, resv_out2=8.
REQ-036 fu_ready=0, three ready issues -> issue_ready=0, busy_count=3; fourth issue ignored; raise fu_ready -> dispatch tags 4, 5, 6 on consecutive cycles.
REQ-037 Issue with issue_qk=5 in the same cycle as cdb_tag=5, CDB=7 -> entry stored with Qk=0, Vk=7.
REQ-038 Assert Reset asynchronously with two busy entries -> outputs 0 immediately; no dispatch after release.
